// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / MDU stalls and precise interrupt entry.
// Latency: stall/bubble are combinational from ID/EX fields; int_ack follows a sampled request by one cycle from IDLE.
// Backpressure: stall holds PC and IF/ID, bubble clears ID/EX; interrupt entry waits until the MDU is idle and no load-use is pending.
//
// Ports:
//   clk, clr                      - clock, synchronous active-high reset
//   id_rs/id_rt/id_use_rs/id_use_rt - source operands of the ID instruction
//   ex_wreg/ex_m2reg/ex_rd          - destination info of the EX instruction
//   id_mdu_start/id_mdu_read        - ID instruction is mult/div or mfhi/mflo
//   intr, int_en                    - level interrupt request and status IE bit
//   stall, bubble, flush, pc_sel_int, int_ack, mdu_busy - pipeline controls
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CW      = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rd,
  input  logic       id_mdu_start,
  input  logic       id_mdu_read,
  input  logic       intr,
  input  logic       int_en,
  output logic       stall,
  output logic       bubble,
  output logic       flush,
  output logic       pc_sel_int,
  output logic       int_ack,
  output logic       mdu_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MDU  = 2'd1,
    S_INTF = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          int_pend_q, int_pend_d;

  logic load_use;
  logic mdu_haz;

  // A load in EX whose destination is read in ID; $0 is never a real dependency.
  assign load_use = ex_m2reg & ex_wreg & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  // Any HI/LO access or a second mult/div must wait for the MDU to drain.
  assign mdu_haz = (state_q == S_MDU) & (id_mdu_read | id_mdu_start);

  // The flush cycle discards IF/ID and ID/EX anyway, so holding them is pointless.
  assign stall  = (load_use | mdu_haz) & (state_q != S_INTF);
  assign bubble = stall;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_pend_d = int_pend_q | (intr & int_en);
    flush      = 1'b0;
    pc_sel_int = 1'b0;
    int_ack    = 1'b0;
    mdu_busy   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending interrupt wins over a mult/div in ID; that instruction is
        // flushed and re-issued after the handler returns.
        if (int_pend_q && !load_use) begin
          state_d = S_INTF;
        end else if (id_mdu_start && !load_use) begin
          state_d = S_MDU;
          cnt_d   = CNT_INIT;
        end
      end
      S_MDU: begin
        mdu_busy = 1'b1;
        // Interrupt entry is deferred to the end of the operation so HI/LO stay precise.
        if (cnt_q == '0) begin
          state_d = int_pend_q ? S_INTF : S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_INTF: begin
        flush      = 1'b1;
        pc_sel_int = 1'b1;
        int_ack    = 1'b1;
        // Clearing here beats a still-high request, forcing at least one IDLE cycle.
        int_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, every cycle compared against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
  logic       id_mdu_start, id_mdu_read, intr, int_en;
  logic       stall, bubble, flush, pc_sel_int, int_ack, mdu_busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CW(6)) dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .intr(intr), .int_en(int_en),
    .stall(stall), .bubble(bubble), .flush(flush), .pc_sel_int(pc_sel_int),
    .int_ack(int_ack), .mdu_busy(mdu_busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: busy cycles still owed by the MDU, flush-cycle flag, pending request.
  int m_left;
  bit m_intf;
  bit m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_idle();
    clr = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
    id_mdu_start = 1'b0; id_mdu_read = 1'b0; intr = 1'b0; int_en = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = r; id_rs = r; id_use_rs = 1'b1;
  endtask

  // Inputs are already applied; compare outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    bit lu, busy, exp_stall;
    @(negedge clk);
    lu = ex_m2reg && ex_wreg && (ex_rd != 5'd0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    busy      = (m_left > 0);
    exp_stall = !m_intf && (lu || (busy && (id_mdu_read || id_mdu_start)));
    check("stall",      32'(stall),      32'(exp_stall));
    check("bubble",     32'(bubble),     32'(exp_stall));
    check("flush",      32'(flush),      32'(m_intf));
    check("pc_sel_int", 32'(pc_sel_int), 32'(m_intf));
    check("int_ack",    32'(int_ack),    32'(m_intf));
    check("mdu_busy",   32'(mdu_busy),   32'(busy));
    @(posedge clk);
    if (clr) begin
      m_left = 0; m_intf = 0; m_pend = 0;
    end else begin
      bit old_pend = m_pend;
      m_pend = m_intf ? 1'b0 : (m_pend || (intr && int_en));
      if (m_intf) begin
        m_intf = 0;
      end else if (busy) begin
        if (m_left == 1 && old_pend) m_intf = 1;
        m_left--;
      end else if (old_pend && !lu) begin
        m_intf = 1;
      end else if (id_mdu_start && !lu) begin
        m_left = MDU_LAT;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    set_idle();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    m_left = 0; m_intf = 0; m_pend = 0;

    // Reset state: everything low.
    step();

    // Load-use on $8: one stall cycle, then the load moves on.
    set_load_use(5'd8); step();
    set_idle(); step();
    // Same pattern targeting $0: no hazard.
    set_load_use(5'd0); step();
    // rt-side dependency.
    set_idle(); ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd31; id_rt = 5'd31; id_use_rt = 1'b1; step();
    set_idle(); step();

    // MDU op with mfhi arriving two cycles later.
    id_mdu_start = 1'b1; step();
    set_idle(); step();
    id_mdu_read = 1'b1; repeat (4) step();
    set_idle(); step();

    // Interrupt from idle; core drops IE on ack.
    int_en = 1'b1; intr = 1'b1; step();
    intr = 1'b0; step();
    int_en = 1'b0; repeat (2) step();

    // Interrupt raised during MDU: deferred until the op drains.
    id_mdu_start = 1'b1; step();
    set_idle(); int_en = 1'b1; intr = 1'b1; step();
    intr = 1'b0; repeat (6) step();

    // Pending interrupt and mult/div in the same idle cycle.
    set_idle(); int_en = 1'b1; intr = 1'b1; step();
    set_idle(); id_mdu_start = 1'b1; step();
    set_idle(); repeat (2) step();

    // Pending interrupt blocked one cycle by load-use.
    int_en = 1'b1; intr = 1'b1; step();
    set_idle(); set_load_use(5'd5); step();
    set_idle(); repeat (3) step();

    // Back-to-back with IE held and request held high.
    int_en = 1'b1; intr = 1'b1; repeat (6) step();
    set_idle(); step();

    // Reset in the middle of an MDU op with a pending interrupt.
    id_mdu_start = 1'b1; step();
    set_idle(); int_en = 1'b1; intr = 1'b1; step();
    set_idle(); clr = 1'b1; step();
    set_idle(); repeat (8) step();

    // Random traffic with small register numbers to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      clr          = ($urandom_range(0, 99) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_wreg      = ($urandom_range(0, 3) != 0);
      ex_m2reg     = ($urandom_range(0, 2) == 0);
      id_mdu_start = ($urandom_range(0, 5) == 0);
      id_mdu_read  = ($urandom_range(0, 4) == 0);
      intr         = ($urandom_range(0, 7) == 0);
      int_en       = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Producer of the `stall`/clear controls that the pipeline registers (PC, IF/ID, ID/EX, EX/MEM) consume in the pipelined CPU.
- Detects load-use hazards and tracks a multi-cycle mult/div unit (MDU).
- Sequences precise interrupt entry: waits for a safe point, then flushes the pipeline and redirects the PC to the interrupt vector.

Parameters:
- MDU_LAT, 4, MDU busy cycles after a start; legal range 2..63.
- CW, 6, width of the MDU countdown counter; must satisfy 2^CW > MDU_LAT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_m2reg  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- id_mdu_start  in  1  ID instruction is mult/div.
- id_mdu_read  in  1  ID instruction is mfhi/mflo.
- intr  in  1  external interrupt request, level.
- int_en  in  1  status IE bit.
- stall  out  1  hold PC and IF/ID (drives their stall inputs).
- bubble  out  1  clear ID/EX (insert nop).
- flush  out  1  clear IF/ID, ID/EX and EX/MEM.
- pc_sel_int  out  1  select interrupt vector as next PC.
- int_ack  out  1  one-cycle interrupt acknowledge; core clears IE and saves EPC.
- mdu_busy  out  1  MDU operation in flight.

Behaviour:
- Reset: while clr=1 at a rising edge, state←IDLE, cnt←0, int_pend←0. All outputs are 0 in the cycle after reset and while in IDLE with no hazard.
- States:
  - IDLE: normal operation.
  - MDU: MDU operation in flight.
  - INTF: one-cycle interrupt flush.
- load_use (combinational) = ex_m2reg & ex_wreg & (ex_rd≠0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- mdu_haz (combinational) = (state==MDU) & (id_mdu_read | id_mdu_start).
- stall = bubble = (load_use | mdu_haz) & (state≠INTF). Load-use stall lasts exactly 1 cycle, because the load advances to MEM.
- int_pend register:
  - Set at an edge when intr & int_en.
  - Cleared at the edge ending INTF.
  - Clear takes priority over set.
- IDLE transitions, in priority order:
  1. int_pend & ~load_use → INTF. An id_mdu_start in the same cycle is ignored; that instruction is flushed and re-executed after return.
  2. id_mdu_start & ~load_use → MDU, cnt←MDU_LAT−1.
  3. Otherwise stay in IDLE.
- MDU:
  - mdu_busy=1.
  - cnt decrements every cycle.
  - When cnt==0: next state is INTF if int_pend, else IDLE.
  - An interrupt never enters INTF while the MDU is busy (precise HI/LO).
  - mfhi/mflo in ID stalls until the cycle after mdu_busy falls, then proceeds.
- INTF:
  - Lasts 1 cycle with flush=1, pc_sel_int=1, int_ack=1, stall=0, bubble=0.
  - Next state is always IDLE.
- Interrupt latency: in IDLE with no hazard, int_ack asserts the cycle after intr is first sampled with int_en=1.
- Back-to-back: intr still high after int_ack does not re-trigger, because the core has cleared int_en. With int_en held 1, a new INTF may follow after at least one IDLE cycle.
- Reset mid-operation: clr overrides everything. An MDU count or a pending interrupt is discarded; outputs are 0 in the next cycle.
- Register-number comparisons are 5-bit exact; $0 never causes a hazard.

Test Plan:
1. Load-use: ex_m2reg=1, ex_wreg=1, ex_rd=8; ID id_rs=8, id_use_rs=1 → stall=bubble=1 for exactly 1 cycle. Same with ex_rd=0 → stall=0.
2. MDU: id_mdu_start in IDLE at cycle 0 → mdu_busy=1 for cycles 1–4 (MDU_LAT=4). mfhi entering ID at cycle 2 → stall=1 in cycles 2–4; stall=0 in cycle 5.
3. Interrupt idle: int_en=1, intr rises at edge N → int_ack=flush=pc_sel_int=1 in cycle N+1 only, then all 0.
4. Interrupt during MDU: start at cycle 0, intr asserted at cycle 1 → no int_ack in cycles 1–4; int_ack in cycle 5; state IDLE in cycle 6.
5. Simultaneous: int_pend=1 and id_mdu_start in the same IDLE cycle → INTF next, mdu_busy stays 0. Interrupt with load_use=1 → INTF delayed by 1 cycle.
6. Reset: clr=1 at cycle 2 of an MDU op with int_pend=1 → in the next cycle mdu_busy=0, stall=0, and no int_ack afterwards while intr=0.
